// File: rtl/h2f_buff_port_arbiter_if.sv
// Avalon-MM style burst master port as seen by the H2F buffer port arbiter.
// The arbiter connects through the slave modport, each requester through master.
interface h2f_buff_port_arbiter_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 128,
    parameter int BE_W    = 16,
    parameter int BURST_W = 5
);
    logic [ADDR_W-1:0]  address;
    logic [BURST_W-1:0] burstcount;
    logic               read;
    logic               write;
    logic [DATA_W-1:0]  writedata;
    logic [BE_W-1:0]    byteenable;
    logic               waitrequest;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/h2f_buff_port_arbiter.sv
// Round-robin burst arbiter for the 128-bit H2F buffer port: grants whole bursts,
// generates per-beat RAM addresses and steers read data back to the issuing master.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | arbitrate; winner's first beat goes to the RAM in the grant cycle
// RD_BURST | issue remaining read beats, one per cycle, both masters held off
// WR_BURST | accept remaining write beats from the owner, stalling on write=0
module h2f_buff_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 128,
    parameter int BE_W    = 16,
    parameter int BURST_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    h2f_buff_port_arbiter_if.slave m0,
    h2f_buff_port_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic [BE_W-1:0]       ram_byteenable,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    localparam logic [BURST_W-1:0] ONE_BEAT  = BURST_W'(1);
    localparam logic [BURST_W-1:0] MAX_BEATS = BURST_W'(16);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;

    state_t             state;
    logic               last_grant;
    logic               owner;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [BURST_W-1:0] remaining;
    logic               rd_vld_q;
    logic               rd_owner_q;

    logic               req0;
    logic               req1;
    logic               grant_sel;
    logic               grant_vld;
    logic [ADDR_W-1:0]  g_address;
    logic [BURST_W-1:0] g_burst;
    logic [BURST_W-1:0] g_beats;
    logic               g_read;
    logic [DATA_W-1:0]  g_wdata;
    logic [BE_W-1:0]    g_be;
    logic               own_write;
    logic [DATA_W-1:0]  own_wdata;
    logic [BE_W-1:0]    own_be;
    logic               wait0;
    logic               wait1;

    // Zero-length bursts run as one beat; oversize bursts are clamped.
    function automatic logic [BURST_W-1:0] eff_beats(input logic [BURST_W-1:0] bc);
        if (bc == '0) begin
            return ONE_BEAT;
        end else if (bc > MAX_BEATS) begin
            return MAX_BEATS;
        end else begin
            return bc;
        end
    endfunction

    always_comb begin
        req0      = m0.read | m0.write;
        req1      = m1.read | m1.write;
        // On a tie the master that did not win last time takes the port.
        grant_sel = req1 & (~req0 | ~last_grant);
        grant_vld = (state == IDLE) & ~reset & (req0 | req1);

        g_address = grant_sel ? m1.address    : m0.address;
        g_burst   = grant_sel ? m1.burstcount : m0.burstcount;
        g_read    = grant_sel ? m1.read       : m0.read;
        g_wdata   = grant_sel ? m1.writedata  : m0.writedata;
        g_be      = grant_sel ? m1.byteenable : m0.byteenable;
        g_beats   = eff_beats(g_burst);

        own_write = owner ? m1.write      : m0.write;
        own_wdata = owner ? m1.writedata  : m0.writedata;
        own_be    = owner ? m1.byteenable : m0.byteenable;
    end

    always_comb begin
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = addr_cnt;
        ram_writedata  = own_wdata;
        ram_byteenable = '1;
        wait0          = 1'b1;
        wait1          = 1'b1;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        ram_chipselect = 1'b1;
                        ram_write      = ~g_read;
                        ram_address    = g_address;
                        ram_writedata  = g_wdata;
                        ram_byteenable = g_read ? '1 : g_be;
                        wait0          = grant_sel;
                        wait1          = ~grant_sel;
                    end
                end
                RD_BURST: begin
                    ram_chipselect = 1'b1;
                end
                WR_BURST: begin
                    wait0 = owner;
                    wait1 = ~owner;
                    if (own_write) begin
                        ram_chipselect = 1'b1;
                        ram_write      = 1'b1;
                        ram_byteenable = own_be;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            addr_cnt   <= '0;
            remaining  <= '0;
            rd_vld_q   <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_vld_q   <= ram_chipselect & ~ram_write;
            rd_owner_q <= (state == IDLE) ? grant_sel : owner;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        last_grant <= grant_sel;
                        owner      <= grant_sel;
                        addr_cnt   <= g_address + 1'b1;
                        remaining  <= g_beats - ONE_BEAT;
                        if (g_beats != ONE_BEAT) begin
                            state <= g_read ? RD_BURST : WR_BURST;
                        end
                    end
                end
                RD_BURST: begin
                    addr_cnt  <= addr_cnt + 1'b1;
                    remaining <= remaining - ONE_BEAT;
                    if (remaining == ONE_BEAT) begin
                        state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (own_write) begin
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - ONE_BEAT;
                        if (remaining == ONE_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ram_clken = 1'b1;

    assign m0.waitrequest   = wait0;
    assign m1.waitrequest   = wait1;
    assign m0.readdata      = ram_readdata;
    assign m1.readdata      = ram_readdata;
    assign m0.readdatavalid = rd_vld_q & ~rd_owner_q & ~reset;
    assign m1.readdatavalid = rd_vld_q & rd_owner_q & ~reset;

endmodule

// File: tb/tb_h2f_buff_port_arbiter.sv
// Bench for the H2F buffer port arbiter: directed scenarios plus a randomized
// two-master run checked against a transaction-level model of the port.
module tb_h2f_buff_port_arbiter;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 128;
    localparam int BE_W    = 16;
    localparam int BURST_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    h2f_buff_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) m0_bus ();
    h2f_buff_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) m1_bus ();

    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_clken;
    logic [DATA_W-1:0] ram_readdata;

    h2f_buff_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .BURST_W(BURST_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
    );

    int checks   = 0;
    int failures = 0;

    // Buffer RAM: unwritten words read back as a fixed address pattern (0x10 -> A5..A5).
    logic [DATA_W-1:0] mem [256];
    logic [255:0]      written = '0;
    logic [DATA_W-1:0] ram_q = '0;
    logic [DATA_W-1:0] model_mem [256];

    function automatic logic [DATA_W-1:0] pattern(input logic [7:0] a);
        return {16{a ^ 8'hB5}};
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] wd,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BE_W; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] env_word(input logic [7:0] a);
        return written[a] ? mem[a] : pattern(a);
    endfunction

    function automatic int eff(input logic [4:0] bc);
        if (bc == 5'd0) return 1;
        if (bc > 5'd16) return 16;
        return int'(bc);
    endfunction

    always @(posedge clk) begin
        if (ram_chipselect && ram_write) begin
            mem[ram_address]     <= merge(env_word(ram_address), ram_writedata, ram_byteenable);
            written[ram_address] <= 1'b1;
        end
        if (ram_chipselect && !ram_write) ram_q <= env_word(ram_address);
    end
    assign ram_readdata = ram_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = '0; m0_bus.burstcount = 5'd1;
        m0_bus.writedata = '0; m0_bus.byteenable = '1;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = '0; m1_bus.burstcount = 5'd1;
        m1_bus.writedata = '0; m1_bus.byteenable = '1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m0_bus.read = 1'b1; m0_bus.burstcount = 5'd4;
        m1_bus.write = 1'b1; m1_bus.burstcount = 5'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (m0_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL reset_m0_wait got=%b want=1", m0_bus.waitrequest); end
            checks++; if (m1_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL reset_m1_wait got=%b want=1", m1_bus.waitrequest); end
            checks++; if (m0_bus.readdatavalid !== 1'b0 || m1_bus.readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%b%b want=00", m0_bus.readdatavalid, m1_bus.readdatavalid); end
            checks++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin failures++; $display("FAIL reset_ram got cs=%b we=%b want 0 0", ram_chipselect, ram_write); end
            checks++; if (ram_clken !== 1'b1) begin failures++; $display("FAIL clken got=%b want=1", ram_clken); end
            tick();
        end
        drive_idle();
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        m0_bus.read = 1'b1; m0_bus.address = 8'h10; m0_bus.burstcount = 5'd1;
        @(negedge clk);
        checks++; if (m0_bus.waitrequest !== 1'b0) begin failures++; $display("FAIL single_m0_wait got=%b want=0", m0_bus.waitrequest); end
        checks++; if (m1_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL single_m1_wait got=%b want=1", m1_bus.waitrequest); end
        checks++; if (ram_chipselect !== 1'b1 || ram_write !== 1'b0 || ram_address !== 8'h10) begin failures++; $display("FAIL single_ram got cs=%b we=%b addr=%0h want 1 0 10", ram_chipselect, ram_write, ram_address); end
        checks++; if (ram_byteenable !== 16'hFFFF) begin failures++; $display("FAIL single_be got=%0h want=ffff", ram_byteenable); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (m0_bus.readdatavalid !== 1'b1 || m1_bus.readdatavalid !== 1'b0) begin failures++; $display("FAIL single_rdv got=%b%b want=10", m0_bus.readdatavalid, m1_bus.readdatavalid); end
        checks++; if (m0_bus.readdata !== {16{8'hA5}}) begin failures++; $display("FAIL single_data got=%0h want=a5..a5", m0_bus.readdata); end
        tick();
    endtask

    task automatic test_alternating();
        logic exp_last, w, prev_v, prev_w;
        logic [7:0] a0, a1;
        logic [DATA_W-1:0] prev_data;
        do_reset();
        exp_last = 1'b1; prev_v = 1'b0; prev_w = 1'b0; prev_data = '0;
        for (int g = 0; g <= 6; g++) begin
            a0 = 8'($urandom); a1 = 8'($urandom);
            m0_bus.read = (g < 6); m0_bus.address = a0; m0_bus.burstcount = 5'($urandom_range(0, 1));
            m1_bus.read = (g < 6); m1_bus.address = a1; m1_bus.burstcount = 5'($urandom_range(0, 1));
            w = ~exp_last;
            @(negedge clk);
            if (g < 6) begin
                checks++; if (m0_bus.waitrequest !== w || m1_bus.waitrequest !== ~w) begin failures++; $display("FAIL alt_grant g=%0d got wait=%b%b want=%b%b", g, m0_bus.waitrequest, m1_bus.waitrequest, w, ~w); end
                checks++; if (ram_address !== (w ? a1 : a0)) begin failures++; $display("FAIL alt_addr g=%0d got=%0h want=%0h", g, ram_address, w ? a1 : a0); end
            end
            checks++; if (m0_bus.readdatavalid !== (prev_v & ~prev_w) || m1_bus.readdatavalid !== (prev_v & prev_w)) begin failures++; $display("FAIL alt_rdv g=%0d got=%b%b want=%b%b", g, m0_bus.readdatavalid, m1_bus.readdatavalid, prev_v & ~prev_w, prev_v & prev_w); end
            if (prev_v) begin
                checks++; if ((prev_w ? m1_bus.readdata : m0_bus.readdata) !== prev_data) begin failures++; $display("FAIL alt_data g=%0d got=%0h want=%0h", g, prev_w ? m1_bus.readdata : m0_bus.readdata, prev_data); end
            end
            prev_v = (g < 6); prev_w = w; prev_data = model_mem[w ? a1 : a0]; exp_last = w;
            tick();
        end
        drive_idle();
    endtask

    task automatic test_write_stall();
        int k;
        logic stall;
        logic [7:0] a;
        k = 0;
        m1_bus.address = 8'hFE; m1_bus.burstcount = 5'd4; m1_bus.byteenable = '1;
        for (int c = 0; c <= 7; c++) begin
            stall = (c == 2 || c == 3);
            m1_bus.write = (c < 6) && !stall;
            m1_bus.writedata = DATA_W'(k + 1);
            m0_bus.read = (c >= 1 && c <= 6); m0_bus.address = 8'h33; m0_bus.burstcount = 5'd1;
            @(negedge clk);
            if (c < 6) begin
                checks++; if (m1_bus.waitrequest !== 1'b0 || m0_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL wr_wait c=%0d got=%b%b want=10", c, m0_bus.waitrequest, m1_bus.waitrequest); end
                checks++; if (ram_chipselect !== !stall) begin failures++; $display("FAIL wr_cs c=%0d got=%b want=%b", c, ram_chipselect, !stall); end
                if (!stall) begin
                    a = 8'hFE + 8'(k);
                    checks++; if (ram_address !== a || ram_write !== 1'b1 || ram_writedata !== DATA_W'(k + 1)) begin failures++; $display("FAIL wr_beat c=%0d got addr=%0h we=%b d=%0h want %0h 1 %0h", c, ram_address, ram_write, ram_writedata, a, k + 1); end
                    k++;
                end
            end else if (c == 6) begin
                checks++; if (m0_bus.waitrequest !== 1'b0 || ram_address !== 8'h33 || ram_chipselect !== 1'b1) begin failures++; $display("FAIL wr_next_grant got wait=%b addr=%0h cs=%b want 0 33 1", m0_bus.waitrequest, ram_address, ram_chipselect); end
            end else begin
                checks++; if (m0_bus.readdatavalid !== 1'b1 || m0_bus.readdata !== model_mem[8'h33]) begin failures++; $display("FAIL wr_next_rdv got v=%b d=%0h want 1 %0h", m0_bus.readdatavalid, m0_bus.readdata, model_mem[8'h33]); end
            end
            tick();
        end
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            a = 8'hFE + 8'(i);
            model_mem[a] = DATA_W'(i + 1);
            checks++; if (env_word(a) !== model_mem[a]) begin failures++; $display("FAIL wr_mem addr=%0h got=%0h want=%0h", a, env_word(a), model_mem[a]); end
        end
    endtask

    task automatic test_long_read();
        for (int c = 0; c <= 17; c++) begin
            m0_bus.read = (c == 0); m0_bus.address = 8'h00; m0_bus.burstcount = 5'd16;
            m1_bus.read = (c >= 1 && c <= 16); m1_bus.address = 8'h40; m1_bus.burstcount = 5'd1;
            @(negedge clk);
            if (c <= 15) begin
                checks++; if (m1_bus.waitrequest !== 1'b1 || ram_chipselect !== 1'b1 || ram_write !== 1'b0 || ram_address !== 8'(c)) begin failures++; $display("FAIL long_beat c=%0d got wait1=%b cs=%b we=%b addr=%0h want 1 1 0 %0h", c, m1_bus.waitrequest, ram_chipselect, ram_write, ram_address, c); end
            end
            if (c == 16) begin
                checks++; if (m1_bus.waitrequest !== 1'b0 || ram_address !== 8'h40) begin failures++; $display("FAIL long_m1_grant got wait=%b addr=%0h want 0 40", m1_bus.waitrequest, ram_address); end
            end
            checks++; if (m0_bus.readdatavalid !== (c >= 1 && c <= 16) || m1_bus.readdatavalid !== (c == 17)) begin failures++; $display("FAIL long_rdv c=%0d got=%b%b", c, m0_bus.readdatavalid, m1_bus.readdatavalid); end
            if (c >= 1 && c <= 16) begin
                checks++; if (m0_bus.readdata !== model_mem[8'(c - 1)]) begin failures++; $display("FAIL long_data c=%0d got=%0h want=%0h", c, m0_bus.readdata, model_mem[8'(c - 1)]); end
            end
            tick();
        end
        drive_idle();
    endtask

    task automatic test_burstcount_clamp();
        logic [4:0] bcs [2];
        int wants [2];
        int n_cs, n_rdv;
        logic [7:0] base;
        bcs[0] = 5'd0; bcs[1] = 5'd31; wants[0] = 1; wants[1] = 16;
        for (int t = 0; t < 2; t++) begin
            n_cs = 0; n_rdv = 0; base = 8'($urandom);
            for (int c = 0; c < 22; c++) begin
                m0_bus.read = (c == 0); m0_bus.address = base; m0_bus.burstcount = bcs[t];
                @(negedge clk);
                if (ram_chipselect) begin
                    checks++; if (ram_address !== base + 8'(n_cs)) begin failures++; $display("FAIL clamp_addr bc=%0d got=%0h want=%0h", bcs[t], ram_address, base + 8'(n_cs)); end
                    n_cs++;
                end
                if (m0_bus.readdatavalid) n_rdv++;
                tick();
            end
            checks++; if (n_cs != wants[t] || n_rdv != wants[t]) begin failures++; $display("FAIL clamp_beats bc=%0d got beats=%0d rdv=%0d want %0d", bcs[t], n_cs, n_rdv, wants[t]); end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c <= 11; c++) begin
            reset = (c == 3);
            m0_bus.read = (c == 0 || c == 10); m0_bus.address = (c == 0) ? 8'h20 : 8'h50;
            m0_bus.burstcount = (c == 0) ? 5'd8 : 5'd1;
            m1_bus.read = (c == 10); m1_bus.address = 8'h60; m1_bus.burstcount = 5'd1;
            @(negedge clk);
            if (c <= 2) begin
                checks++; if (ram_chipselect !== 1'b1 || ram_address !== 8'h20 + 8'(c)) begin failures++; $display("FAIL rst_pre c=%0d got cs=%b addr=%0h", c, ram_chipselect, ram_address); end
            end else if (c <= 9) begin
                checks++; if (ram_chipselect !== 1'b0) begin failures++; $display("FAIL rst_cs c=%0d got=%b want=0", c, ram_chipselect); end
                checks++; if (m0_bus.readdatavalid !== 1'b0 || m1_bus.readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_rdv c=%0d got=%b%b want=00", c, m0_bus.readdatavalid, m1_bus.readdatavalid); end
            end else if (c == 10) begin
                checks++; if (m0_bus.waitrequest !== 1'b0 || m1_bus.waitrequest !== 1'b1) begin failures++; $display("FAIL rst_tie got wait=%b%b want=01", m0_bus.waitrequest, m1_bus.waitrequest); end
            end else begin
                checks++; if (m0_bus.readdatavalid !== 1'b1 || m1_bus.readdatavalid !== 1'b0) begin failures++; $display("FAIL rst_tie_rdv got=%b%b want=10", m0_bus.readdatavalid, m1_bus.readdatavalid); end
            end
            tick();
        end
        reset = 1'b0;
        drive_idle();
    endtask

    task automatic test_random();
        int d_state [2];
        logic d_read [2];
        logic [7:0] d_addr [2];
        logic [4:0] d_bc [2];
        int d_beats [2];
        int d_k [2];
        logic in_rd [2];
        logic in_wr [2];
        logic [7:0] in_addr [2];
        logic [4:0] in_bc [2];
        logic [DATA_W-1:0] in_wd [2];
        logic [BE_W-1:0] in_be [2];
        int beats_left;
        logic owner, is_rd, last, w, pv, po;
        logic [7:0] nxt;
        logic [DATA_W-1:0] pdata;
        logic [1:0] exp_wait;
        logic exp_cs, exp_we;
        logic [7:0] exp_addr;
        logic [DATA_W-1:0] exp_wd;
        logic [BE_W-1:0] exp_be;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            d_state[i] = 0; d_read[i] = 1'b0; d_addr[i] = '0; d_bc[i] = 5'd1; d_beats[i] = 1; d_k[i] = 0;
        end
        beats_left = 0; owner = 1'b0; is_rd = 1'b0; last = 1'b1; pv = 1'b0; po = 1'b0; nxt = '0; pdata = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (d_state[i] == 0 && cyc < 700 && $urandom_range(0, 2) == 0) begin
                    d_read[i] = 1'($urandom_range(0, 1)); d_addr[i] = 8'($urandom); d_bc[i] = 5'($urandom);
                    d_beats[i] = eff(d_bc[i]); d_k[i] = 0; d_state[i] = 1;
                end
                in_rd[i]   = (d_state[i] == 1) && d_read[i];
                in_wr[i]   = ((d_state[i] == 1) && (!d_read[i] || $urandom_range(0, 4) == 0)) ||
                             ((d_state[i] == 2) && $urandom_range(0, 3) != 0);
                in_addr[i] = (d_state[i] != 0) ? d_addr[i] : 8'($urandom);
                in_bc[i]   = d_bc[i];
                in_wd[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_be[i]   = 16'($urandom);
            end
            m0_bus.read = in_rd[0]; m0_bus.write = in_wr[0]; m0_bus.address = in_addr[0];
            m0_bus.burstcount = in_bc[0]; m0_bus.writedata = in_wd[0]; m0_bus.byteenable = in_be[0];
            m1_bus.read = in_rd[1]; m1_bus.write = in_wr[1]; m1_bus.address = in_addr[1];
            m1_bus.burstcount = in_bc[1]; m1_bus.writedata = in_wd[1]; m1_bus.byteenable = in_be[1];
            @(negedge clk);
            checks++; if (m0_bus.readdatavalid !== (pv & ~po) || m1_bus.readdatavalid !== (pv & po)) begin failures++; $display("FAIL rnd_rdv cyc=%0d got=%b%b want=%b%b", cyc, m0_bus.readdatavalid, m1_bus.readdatavalid, pv & ~po, pv & po); end
            if (pv) begin
                checks++; if ((po ? m1_bus.readdata : m0_bus.readdata) !== pdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%0h want=%0h", cyc, po ? m1_bus.readdata : m0_bus.readdata, pdata); end
            end
            exp_wait = 2'b11; exp_cs = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_be = '1;
            if (beats_left == 0) begin
                if (in_rd[0] | in_wr[0] | in_rd[1] | in_wr[1]) begin
                    w = ((in_rd[0] | in_wr[0]) && (in_rd[1] | in_wr[1])) ? ~last : (in_rd[1] | in_wr[1]);
                    exp_wait[w] = 1'b0; exp_cs = 1'b1; exp_we = ~in_rd[w]; exp_addr = in_addr[w];
                    exp_wd = in_wd[w]; exp_be = in_rd[w] ? '1 : in_be[w];
                    beats_left = eff(in_bc[w]) - 1; owner = w; is_rd = in_rd[w]; nxt = in_addr[w] + 8'd1; last = w;
                    if (in_rd[w]) d_state[w] = 0;
                    else begin d_k[w] = 1; d_state[w] = (d_beats[w] == 1) ? 0 : 2; end
                end
            end else if (is_rd) begin
                exp_cs = 1'b1; exp_addr = nxt; nxt = nxt + 8'd1; beats_left--;
            end else begin
                exp_wait[owner] = 1'b0;
                if (in_wr[owner]) begin
                    exp_cs = 1'b1; exp_we = 1'b1; exp_addr = nxt; exp_wd = in_wd[owner]; exp_be = in_be[owner];
                    nxt = nxt + 8'd1; beats_left--; d_k[owner]++;
                    if (d_k[owner] == d_beats[owner]) d_state[owner] = 0;
                end
            end
            checks++; if ({m1_bus.waitrequest, m0_bus.waitrequest} !== exp_wait) begin failures++; $display("FAIL rnd_wait cyc=%0d got=%b%b want=%b", cyc, m1_bus.waitrequest, m0_bus.waitrequest, exp_wait); end
            checks++; if (ram_chipselect !== exp_cs) begin failures++; $display("FAIL rnd_cs cyc=%0d got=%b want=%b", cyc, ram_chipselect, exp_cs); end
            if (exp_cs) begin
                checks++; if (ram_write !== exp_we || ram_address !== exp_addr || ram_byteenable !== exp_be) begin failures++; $display("FAIL rnd_cmd cyc=%0d got we=%b a=%0h be=%0h want %b %0h %0h", cyc, ram_write, ram_address, ram_byteenable, exp_we, exp_addr, exp_be); end
                if (exp_we) begin
                    checks++; if (ram_writedata !== exp_wd) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%0h want=%0h", cyc, ram_writedata, exp_wd); end
                    model_mem[exp_addr] = merge(model_mem[exp_addr], exp_wd, exp_be);
                end
            end
            pv = exp_cs & ~exp_we;
            po = (exp_wait == 2'b11) ? owner : exp_wait[0];
            pdata = model_mem[exp_addr];
            tick();
        end
        drive_idle();
        @(negedge clk);
        checks++; if (m0_bus.readdatavalid !== (pv & ~po) || m1_bus.readdatavalid !== (pv & po)) begin failures++; $display("FAIL rnd_tail_rdv got=%b%b want=%b%b", m0_bus.readdatavalid, m1_bus.readdatavalid, pv & ~po, pv & po); end
        checks++; if (d_state[0] != 0 || d_state[1] != 0 || beats_left != 0) begin failures++; $display("FAIL rnd_drain got states=%0d,%0d left=%0d want 0,0,0", d_state[0], d_state[1], beats_left); end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        for (int i = 0; i < 256; i++) model_mem[i] = pattern(8'(i));
        repeat (2) tick();
        test_reset();
        test_single_read();
        test_alternating();
        test_write_stall();
        test_long_read();
        test_burstcount_clamp();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
